// File: rtl/cnn_pkg.sv
// Shared constants and elaboration helpers for the CNN accumulating adder tree.
package cnn_pkg;

  localparam int N_IN_DEF   = 9;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int tree_w(input int data_w, input int lvl);
    return data_w + lvl;
  endfunction

  // Number of terms entering tree level lvl when the tree starts with n operands.
  function automatic int terms_at(input int n, input int lvl);
    int t;
    t = n;
    for (int i = 0; i < lvl; i++) t = (t + 1) / 2;
    return t;
  endfunction

  localparam int LVL_DEF = clog2(N_IN_DEF);

endpackage

// File: rtl/cnn_acc_adder_tree_add_level.sv
// One registered adder-tree level: sums adjacent term pairs, passes an odd leftover through.
module cnn_add_level #(
  parameter int N_TERMS = 2,
  parameter int IN_W    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  in_valid,
  input  logic                                  in_first,
  input  logic                                  in_last,
  input  logic [N_TERMS*IN_W-1:0]               in_terms,
  output logic                                  out_valid,
  output logic                                  out_first,
  output logic                                  out_last,
  output logic [((N_TERMS+1)/2)*(IN_W+1)-1:0]   out_terms
);

  localparam int N_OUT = (N_TERMS + 1) / 2;
  localparam int OUT_W = IN_W + 1;

  logic [N_OUT*OUT_W-1:0] nxt_terms;

  for (genvar k = 0; k < N_OUT; k++) begin : g_pair
    if (2*k + 1 < N_TERMS) begin : g_add
      assign nxt_terms[k*OUT_W +: OUT_W] = OUT_W'(in_terms[2*k*IN_W +: IN_W])
                                         + OUT_W'(in_terms[(2*k+1)*IN_W +: IN_W]);
    end else begin : g_pass
      assign nxt_terms[k*OUT_W +: OUT_W] = OUT_W'(in_terms[2*k*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_terms <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_first <= in_first;
      out_last  <= in_last;
      out_terms <= nxt_terms;
    end
  end

endmodule

// File: rtl/cnn_acc_adder_tree.sv
// Pipelined unsigned adder tree with per-packet accumulator and valid/ready on both sides.
// Define CNN_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module cnn_acc_adder_tree
  import cnn_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_ovf
);

  localparam int LVL   = (N_IN == N_IN_DEF) ? LVL_DEF : clog2(N_IN);
  localparam int SUM_W = tree_w(DATA_W, LVL);

  // The whole pipeline moves as one unit; a held output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             t_vld, t_fst, t_lst;
  logic [SUM_W-1:0] t_sum;

  if (LVL == 0) begin : g_direct
    assign t_vld = in_valid;
    assign t_fst = in_first;
    assign t_lst = in_last;
    assign t_sum = in_data;
  end else begin : g_tree
    for (genvar i = 0; i < LVL; i++) begin : g_lvl
      localparam int NT = terms_at(N_IN, i);
      localparam int IW = tree_w(DATA_W, i);
      localparam int NO = (NT + 1) / 2;

      logic [NT*IW-1:0]     src;
      logic                 src_vld, src_fst, src_lst;
      logic [NO*(IW+1)-1:0] terms;
      logic                 vld, fst, lst;

      if (i == 0) begin : g_src
        assign src     = in_data;
        assign src_vld = in_valid;
        assign src_fst = in_first;
        assign src_lst = in_last;
      end else begin : g_src
        assign src     = g_lvl[i-1].terms;
        assign src_vld = g_lvl[i-1].vld;
        assign src_fst = g_lvl[i-1].fst;
        assign src_lst = g_lvl[i-1].lst;
      end

      cnn_add_level #(
        .N_TERMS (NT),
        .IN_W    (IW)
      ) u_level (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .in_valid  (src_vld),
        .in_first  (src_fst),
        .in_last   (src_lst),
        .in_terms  (src),
        .out_valid (vld),
        .out_first (fst),
        .out_last  (lst),
        .out_terms (terms)
      );
    end

    assign t_vld = g_lvl[LVL-1].vld;
    assign t_fst = g_lvl[LVL-1].fst;
    assign t_lst = g_lvl[LVL-1].lst;
    assign t_sum = g_lvl[LVL-1].terms;
  end

  logic [ACC_W-1:0] acc, ext, base, raw, nxt_acc;
  logic             ovf, nxt_ovf, carry;

  assign ext = ACC_W'(t_sum);

  always_comb begin
    base    = t_fst ? '0 : acc;
    {carry, raw} = {1'b0, base} + {1'b0, ext};
    nxt_ovf = (!t_fst && ovf) || carry;
`ifdef CNN_ACC_SAT_EN
    nxt_acc = nxt_ovf ? '1 : raw;
`else
    nxt_acc = raw;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= t_vld && t_lst;
      if (t_vld) begin
        if (t_lst) begin
          out_data <= nxt_acc;
          out_ovf  <= nxt_ovf;
          acc      <= '0;
          ovf      <= 1'b0;
        end else begin
          acc <= nxt_acc;
          ovf <= nxt_ovf;
        end
      end
    end
  end

endmodule
